clk_step_ctrl: RTL and testbench
================================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the burst length and cycles_left.
REQ-002 The block SHALL have parameter CYC_W, default 32: width of the enabled-cycle counter.
REQ-003 The block SHALL have parameter ADDR_W, default 16: breakpoint address width.
REQ-004 The block SHALL have port clk_in, input, 1: single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port active, input, 1: 1 = stepper controls the enable; 0 = free-run.
REQ-007 The block SHALL have port step, input, 1: level input; a 0->1 transition requests a burst.
REQ-008 The block SHALL have port step_count, input, CNT_W: enabled cycles per burst; 0 is treated as 1.
REQ-009 The block SHALL have port addr, input, ADDR_W: current bus address from the core, for breakpoint compare.
REQ-010 The block SHALL have port bp_addr, input, ADDR_W: breakpoint address.
REQ-011 The block SHALL have port bp_en, input, 1: breakpoint enable.
REQ-012 The block SHALL have port clk_en, output, 1: clock enable to downstream logic; no gated clock is produced.
REQ-013 The block SHALL have port halted, output, 1: high while in HALT.
REQ-014 The block SHALL have port cycles_left, output, CNT_W: remaining enabled cycles in the current burst.
REQ-015 The block SHALL have port cycle_cnt, output, CYC_W: count of cycles with clk_en=1.

Function
REQ-016 The block SHALL implement states FREE, HALT and BURST, with clk_en=1 in FREE and BURST and 0 in HALT, decoded from the state register.
REQ-017 The block SHALL detect a step edge as step=1 with its registered previous value step_d=0.
REQ-018 In FREE, when active=1 is sampled, the block SHALL enter HALT at the next edge, giving one cycle of latency before clk_en drops.
REQ-019 In HALT, when active=0 is sampled, the block SHALL enter FREE; this takes priority over a simultaneous step edge.
REQ-020 In HALT, on a step edge with active=1, the block SHALL enter BURST and load cycles_left with step_count, or with 1 if step_count=0.
REQ-021 In BURST, the block SHALL decrement cycles_left each cycle; when cycles_left=1 it SHALL enter HALT with cycles_left=0, so exactly N enabled cycles occur per burst.
REQ-022 In BURST, active=0 SHALL force FREE and clear cycles_left.
REQ-023 Step edges during BURST or FREE SHALL be ignored and SHALL NOT be queued.
REQ-024 The block SHALL increment cycle_cnt on every cycle with clk_en=1, wrapping from all-ones to 0.
REQ-025 cycles_left SHALL NOT underflow; it holds 0 outside BURST.

Reset
REQ-026 With rst_n=0 sampled, the block SHALL set state=FREE, clk_en=1, halted=0, cycles_left=0 and cycle_cnt=0.
REQ-027 On reset, step_d SHALL be set to 1 so that step held high through reset produces no burst.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no residual count; after reset releases, active=1 gives HALT one cycle later.

Configuration
REQ-029 The breakpoint feature SHALL be controlled by macro CLK_STEP_BREAK_EN.
REQ-030 With CLK_STEP_BREAK_EN defined: in FREE or BURST with active=1, bp_en=1 and addr==bp_addr sampled, the block SHALL enter HALT at the next edge and clear cycles_left; the breakpoint takes precedence over burst decrement.
REQ-031 Without CLK_STEP_BREAK_EN: addr, bp_addr and bp_en SHALL remain as ports but SHALL be ignored, and no comparator SHALL be synthesised.

Verification
REQ-032 The bench SHALL cover: reset, active=0 for 10 cycles -> clk_en=1 throughout, cycle_cnt=10.
REQ-033 The bench SHALL cover: active=1, step_count=3, one step pulse -> exactly 3 clk_en cycles, cycles_left 3,2,1,0, halted=1 afterwards.
REQ-034 The bench SHALL cover: step_count=0, step pulse -> exactly 1 enabled cycle; step held high for 5 cycles -> only one burst.
REQ-035 The bench SHALL cover: active dropped to 0 mid-burst (cycles_left=5) -> FREE next cycle, cycles_left=0, clk_en=1.
REQ-036 The bench SHALL cover, with CLK_STEP_BREAK_EN: bp_addr=16'hC000, bp_en=1, active=1, step_count=200 burst, addr reaches C000 at cycle 7 -> HALT next cycle, cycle_cnt advanced by 7 or 8 per the REQ-030 edge timing.
REQ-037 The bench SHALL cover: rst_n=0 mid-burst with step held high -> FREE, counters 0, and no burst after release until step goes low then high.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// Clock-enable stepper: free-run, halt, or N-cycle bursts on a step edge.
// Optional address breakpoint enabled by defining CLK_STEP_BREAK_EN.
module clk_step_ctrl #(
  parameter int CNT_W  = 8,
  parameter int CYC_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              active,
  input  logic              step,
  input  logic [CNT_W-1:0]  step_count,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_en,
  output logic              clk_en,
  output logic              halted,
  output logic [CNT_W-1:0]  cycles_left,
  output logic [CYC_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    HALT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cl_n;
  logic [CNT_W-1:0] cl_load;
  logic             step_d;
  logic             step_edge;
  logic             bp_hit;

`ifdef CLK_STEP_BREAK_EN
  assign bp_hit = bp_en && (addr == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{addr, bp_addr, bp_en};
  assign bp_hit    = 1'b0;
`endif

  assign step_edge = step && !step_d;
  assign cl_load   = (step_count == '0) ?
                     {{(CNT_W-1){1'b0}}, 1'b1} : step_count;

  assign clk_en = (state != HALT);
  assign halted = (state == HALT);

  always_comb begin
    state_n = state;
    cl_n    = cycles_left;
    unique case (state)
      FREE: begin
        cl_n = '0;
        if (active) state_n = HALT;
      end
      HALT: begin
        cl_n = '0;
        if (!active) begin
          state_n = FREE;
        end else if (step_edge) begin
          state_n = BURST;
          cl_n    = cl_load;
        end
      end
      BURST: begin
        if (!active) begin
          state_n = FREE;
          cl_n    = '0;
        end else if (bp_hit) begin
          state_n = HALT;
          cl_n    = '0;
        end else if (cycles_left <= 1) begin
          // last enabled cycle of the burst; never wraps below zero
          state_n = HALT;
          cl_n    = '0;
        end else begin
          cl_n = cycles_left - 1'b1;
        end
      end
      default: begin
        state_n = FREE;
        cl_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= FREE;
      cycles_left <= '0;
      cycle_cnt   <= '0;
      // held-high step through reset must not look like an edge
      step_d      <= 1'b1;
    end else begin
      state       <= state_n;
      cycles_left <= cl_n;
      step_d      <= step;
      if (clk_en) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed vector bench for clk_step_ctrl.
// Define CLK_STEP_BREAK_EN to check the breakpoint path.
module tb_clk_step_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        active = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  step_count = 8'd0;
  logic [15:0] addr = 16'd0;
  logic [15:0] bp_addr = 16'd0;
  logic        bp_en = 1'b0;
  logic        clk_en;
  logic        halted;
  logic [7:0]  cycles_left;
  logic [31:0] cycle_cnt;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst_n;
    logic        active;
    logic        step;
    logic [7:0]  sc;
    logic        en;
    logic        h;
    logic [7:0]  cl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  clk_step_ctrl dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .active      (active),
    .step        (step),
    .step_count  (step_count),
    .addr        (addr),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .clk_en      (clk_en),
    .halted      (halted),
    .cycles_left (cycles_left),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic add(input logic r, input logic a, input logic s,
                     input logic [7:0] sc, input logic en,
                     input logic h, input logic [7:0] cl,
                     input logic [31:0] cnt);
    vec_t v;
    v.rst_n = r; v.active = a; v.step = s; v.sc = sc;
    v.en = en; v.h = h; v.cl = cl; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic en,
                       input logic h, input logic [7:0] cl,
                       input logic [31:0] cnt);
    n_vec++;
    if (clk_en !== en || halted !== h ||
        cycles_left !== cl || cycle_cnt !== cnt) begin
      n_bad++;
      $display("FAIL %s got en=%b h=%b cl=%0d cnt=%0d want en=%b h=%b cl=%0d cnt=%0d",
               name, clk_en, halted, cycles_left, cycle_cnt,
               en, h, cl, cnt);
    end
  endtask

  task automatic tick(input logic r, input logic a, input logic s,
                      input logic [7:0] sc);
    rst_n = r; active = a; step = s; step_count = sc;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // reset
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    // free-run ten cycles
    for (int i = 1; i <= 10; i++)
      add(1, 0, 0, 0, 1, 0, 0, 32'(i));
    // enter halt, one cycle latency
    add(1, 1, 0, 0, 0, 1, 0, 11);
    add(1, 1, 0, 0, 0, 1, 0, 11);
    // burst of 3
    add(1, 1, 1, 3, 1, 0, 3, 11);
    add(1, 1, 0, 3, 1, 0, 2, 12);
    add(1, 1, 0, 3, 1, 0, 1, 13);
    add(1, 1, 0, 3, 0, 1, 0, 14);
    add(1, 1, 0, 3, 0, 1, 0, 14);
    // step_count 0 acts as 1, step held high 5 cycles
    add(1, 1, 1, 0, 1, 0, 1, 14);
    for (int i = 0; i < 4; i++)
      add(1, 1, 1, 0, 0, 1, 0, 15);
    add(1, 1, 0, 0, 0, 1, 0, 15);
    // drop active mid-burst at cycles_left=5
    add(1, 1, 1, 5, 1, 0, 5, 15);
    add(1, 0, 0, 5, 1, 0, 0, 16);
    add(1, 0, 0, 5, 1, 0, 0, 17);
    // step in FREE is not queued
    add(1, 0, 1, 5, 1, 0, 0, 18);
    add(1, 1, 1, 5, 0, 1, 0, 19);
    add(1, 1, 1, 5, 0, 1, 0, 19);
    add(1, 1, 0, 5, 0, 1, 0, 19);

    foreach (tbl[i]) begin
      tick(tbl[i].rst_n, tbl[i].active, tbl[i].step, tbl[i].sc);
      check($sformatf("vec%0d", i), tbl[i].en, tbl[i].h,
            tbl[i].cl, tbl[i].cnt);
    end

    // reset mid-burst with step held high
    tick(1, 1, 1, 4);
    check("rst_burst", 1, 0, 4, 19);
    tick(0, 1, 1, 4);
    check("rst_in", 1, 0, 0, 0);
    tick(1, 1, 1, 4);
    check("rst_halt", 0, 1, 0, 1);
    tick(1, 1, 1, 4);
    check("rst_nostep1", 0, 1, 0, 1);
    tick(1, 1, 1, 4);
    check("rst_nostep2", 0, 1, 0, 1);
    tick(1, 1, 0, 4);
    check("rst_low", 0, 1, 0, 1);
    tick(1, 1, 1, 4);
    check("rst_rearm", 1, 0, 4, 1);

    // breakpoint during a long burst
    bp_addr = 16'hC000;
    bp_en   = 1'b1;
    addr    = 16'h0000;
    tick(0, 0, 0, 200);
    check("bp_rst", 1, 0, 0, 0);
    tick(1, 1, 0, 200);
    check("bp_halt", 0, 1, 0, 1);
    tick(1, 1, 1, 200);
    check("bp_burst", 1, 0, 200, 1);
    for (int k = 1; k <= 7; k++) begin
      addr = (k == 7) ? 16'hC000 : 16'(k);
      tick(1, 1, 0, 200);
`ifdef CLK_STEP_BREAK_EN
      if (k == 7)
        check("bp_hit", 0, 1, 0, 8);
      else
`endif
        check($sformatf("bp_run%0d", k), 1, 0,
              8'(200 - k), 32'(1 + k));
    end
    tick(1, 1, 0, 200);
`ifdef CLK_STEP_BREAK_EN
    check("bp_stay", 0, 1, 0, 8);
`else
    check("bp_ignored", 1, 0, 192, 9);
`endif
    addr = 16'h0000;
    tick(1, 0, 0, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
